// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared rename-stage constants and types
package rv32i_types;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PW        = $clog2(NUM_PREGS);

  typedef logic [PW-1:0] preg_idx_t;

  typedef struct packed {
    logic      valid;
    logic [4:0] arch_rd;
    preg_idx_t preg;
  } fl_alloc_t;

endpackage

// File: rtl/fl_prio_pick.sv
// rtl/fl_prio_pick.sv - lowest-index set-bit finder
module fl_prio_pick #(
  parameter int WIDTH = 64,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/free_list_mw.sv
// rtl/free_list_mw.sv - multi-port physical register free list for rename
// Optional FL_FREE_BYPASS_EN: same-cycle frees become allocation candidates.
module free_list_mw #(
  parameter int NUM_PREGS = rv32i_types::NUM_PREGS,
  parameter int NUM_AREGS = rv32i_types::NUM_AREGS,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int PW        = $clog2(NUM_PREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_AREGS*PW-1:0] rrf_map,
  input  logic [ALLOC_W-1:0]      alloc_req,
  input  logic [ALLOC_W*5-1:0]    alloc_arch_rd,
  output logic [ALLOC_W*PW-1:0]   alloc_preg,
  output logic [ALLOC_W-1:0]      alloc_gnt,
  input  logic [FREE_W-1:0]       free_valid,
  input  logic [FREE_W*PW-1:0]    free_preg,
  output logic [PW:0]             free_count,
  output logic                    empty
);

`ifdef FL_FREE_BYPASS_EN
  localparam int CW = NUM_PREGS + FREE_W;
`else
  localparam int CW = NUM_PREGS;
`endif
  localparam int CIW = $clog2(CW);
  localparam logic [NUM_PREGS-1:0] RESET_BUSY =
    {{(NUM_PREGS-NUM_AREGS){1'b0}}, {NUM_AREGS{1'b1}}};

  logic [NUM_PREGS-1:0] busy;
  logic [NUM_PREGS-1:0] busy_next;
  logic [NUM_PREGS-1:0] rrf_busy;
  logic [PW-1:0]        fr_idx [FREE_W];
  logic [FREE_W-1:0]    fr_ok;
  logic                 dbl_free_err;
  logic                 dup_free_err;
  logic [CW-1:0]        cand [ALLOC_W+1];
  logic                 ok_chain [ALLOC_W+1];
  logic [ALLOC_W-1:0]   take_vec;
  logic [PW-1:0]        take_preg [ALLOC_W];
  logic [PW:0]          n_take;
  logic [PW:0]          n_free;

  function automatic logic [PW:0] count_ones(input logic [NUM_PREGS-1:0] v);
    count_ones = '0;
    for (int i = 0; i < NUM_PREGS; i++) count_ones = count_ones + (PW+1)'(v[i]);
  endfunction

  // A free only counts if it clears a busy, non-zero preg not already freed by an earlier slot.
  always_comb begin
    fr_ok        = '0;
    dbl_free_err = 1'b0;
    dup_free_err = 1'b0;
    for (int j = 0; j < FREE_W; j++) begin
      fr_idx[j] = free_preg[j*PW +: PW];
      fr_ok[j]  = free_valid[j] && (fr_idx[j] != '0) && busy[fr_idx[j]];
      if (free_valid[j] && (fr_idx[j] != '0) && !busy[fr_idx[j]]) dbl_free_err = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (free_valid[i] && free_valid[j] && (fr_idx[i] == fr_idx[j]) && (fr_idx[j] != '0)) begin
          dup_free_err = 1'b1;
          fr_ok[j]     = 1'b0;
        end
      end
    end
  end

`ifdef FL_FREE_BYPASS_EN
  assign cand[0] = {fr_ok, busy_n_stored()};
`else
  assign cand[0] = busy_n_stored();
`endif

  function automatic logic [NUM_PREGS-1:0] busy_n_stored();
    busy_n_stored    = ~busy;
    busy_n_stored[0] = 1'b0;
  endfunction

  assign ok_chain[0] = !rst && !flush;

  for (genvar k = 0; k < ALLOC_W; k++) begin : g_slot
    logic [CIW-1:0] pidx;
    logic           pfound;
    logic           zero_rd;
    logic [PW-1:0]  preg_k;

    fl_prio_pick #(.WIDTH(CW), .IW(CIW)) u_pick (
      .vec   (cand[k]),
      .idx   (pidx),
      .found (pfound)
    );

    // Candidates above NUM_PREGS-1 are bypassed frees, mapped back through their slot.
    always_comb begin
      preg_k = pidx[PW-1:0];
      for (int j = 0; j < FREE_W; j++) begin
        if (int'(pidx) == NUM_PREGS + j) preg_k = fr_idx[j];
      end
    end

    assign zero_rd          = (alloc_arch_rd[k*5 +: 5] == 5'd0);
    assign alloc_gnt[k]     = ok_chain[k] && alloc_req[k] && (zero_rd || pfound);
    assign take_vec[k]      = alloc_gnt[k] && !zero_rd;
    assign take_preg[k]     = preg_k;
    assign alloc_preg[k*PW +: PW] = take_vec[k] ? preg_k : '0;
    assign cand[k+1]        = take_vec[k] ? (cand[k] & ~(CW'(1) << pidx)) : cand[k];
    assign ok_chain[k+1]    = ok_chain[k] && (!alloc_req[k] || alloc_gnt[k]);
  end

  // Clears first, then sets, so a bypassed preg that is regranted stays busy.
  always_comb begin
    busy_next = busy;
    n_take    = '0;
    n_free    = '0;
    for (int j = 0; j < FREE_W; j++) begin
      if (fr_ok[j]) busy_next[fr_idx[j]] = 1'b0;
      n_free = n_free + (PW+1)'(fr_ok[j]);
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      if (take_vec[k]) busy_next[take_preg[k]] = 1'b1;
      n_take = n_take + (PW+1)'(take_vec[k]);
    end
    busy_next[0] = 1'b1;
  end

  always_comb begin
    rrf_busy    = '0;
    rrf_busy[0] = 1'b1;
    for (int i = 0; i < NUM_AREGS; i++) rrf_busy[rrf_map[i*PW +: PW]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= RESET_BUSY;
      free_count <= (PW+1)'(NUM_PREGS - NUM_AREGS);
    end else if (flush) begin
      busy       <= rrf_busy;
      free_count <= (PW+1)'(NUM_PREGS) - count_ones(rrf_busy);
    end else begin
      busy       <= busy_next;
      free_count <= free_count - n_take + n_free;
    end
  end

  assign empty = (free_count == '0);

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!dbl_free_err) else $warning("free_list_mw: free of a preg that is already free");
      assert (!dup_free_err) else $warning("free_list_mw: duplicate free_preg within one cycle");
    end
  end

endmodule

// File: tb/tb_free_list_mw.sv
// tb/tb_free_list_mw.sv - directed self-checking bench for free_list_mw
module tb_free_list_mw;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int AW = 2;
  localparam int FW = 2;
  localparam int PW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NA*PW-1:0]  rrf_map;
  logic [AW-1:0]     alloc_req;
  logic [AW*5-1:0]   alloc_arch_rd;
  logic [AW*PW-1:0]  alloc_preg;
  logic [AW-1:0]     alloc_gnt;
  logic [FW-1:0]     free_valid;
  logic [FW*PW-1:0]  free_preg;
  logic [PW:0]       free_count;
  logic              empty;

  int checks = 0;
  int errors = 0;

  free_list_mw #(.NUM_PREGS(NP), .NUM_AREGS(NA), .ALLOC_W(AW), .FREE_W(FW), .PW(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .rrf_map       (rrf_map),
    .alloc_req     (alloc_req),
    .alloc_arch_rd (alloc_arch_rd),
    .alloc_preg    (alloc_preg),
    .alloc_gnt     (alloc_gnt),
    .free_valid    (free_valid),
    .free_preg     (free_preg),
    .free_count    (free_count),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic [1:0] req, input logic [4:0] rd0, input logic [4:0] rd1);
    alloc_req     = req;
    alloc_arch_rd = {rd1, rd0};
  endtask

  task automatic set_free(input logic [1:0] v, input logic [5:0] p0, input logic [5:0] p1);
    free_valid = v;
    free_preg  = {p1, p0};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rrf_map = '0;
    set_alloc(2'b11, 5'd5, 5'd6);
    set_free(2'b00, 6'd0, 6'd0);
    #1;
    checks++;
    if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", alloc_gnt); end
    tick(); tick();
    checks++;
    if (free_count !== 7'd32) begin errors++; $display("FAIL reset_count got %0d want 32", free_count); end
    checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %b want 0", empty); end
    rst = 1'b0;
    set_alloc(2'b00, 5'd0, 5'd0);
  endtask

  task automatic test_basic_alloc();
    set_alloc(2'b11, 5'd5, 5'd6);
    #1;
    checks++;
    if (alloc_gnt !== 2'b11 || alloc_preg !== {6'd33, 6'd32}) begin
      errors++; $display("FAIL basic_alloc got gnt=%b preg=%h want gnt=11 preg0=32 preg1=33", alloc_gnt, alloc_preg);
    end
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd30) begin errors++; $display("FAIL basic_count got %0d want 30", free_count); end
  endtask

  task automatic test_zero_rd();
    set_alloc(2'b11, 5'd0, 5'd7);
    #1;
    checks++;
    if (alloc_gnt !== 2'b11 || alloc_preg !== {6'd34, 6'd0}) begin
      errors++; $display("FAIL zero_rd got gnt=%b preg=%h want gnt=11 preg0=0 preg1=34", alloc_gnt, alloc_preg);
    end
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd29) begin errors++; $display("FAIL zero_rd_count got %0d want 29", free_count); end
  endtask

  task automatic test_free_visibility();
    set_free(2'b01, 6'd33, 6'd0);
    set_alloc(2'b01, 5'd3, 5'd0);
    #1;
    checks++;
    if (alloc_gnt !== 2'b01 || alloc_preg[5:0] !== 6'd35) begin
      errors++; $display("FAIL free_same_cycle got gnt=%b preg0=%0d want gnt=01 preg0=35", alloc_gnt, alloc_preg[5:0]);
    end
    tick();
    set_free(2'b00, 6'd0, 6'd0);
    checks++;
    if (free_count !== 7'd29) begin errors++; $display("FAIL free_alloc_count got %0d want 29", free_count); end
    #1;
    checks++;
    if (alloc_gnt !== 2'b01 || alloc_preg[5:0] !== 6'd33) begin
      errors++; $display("FAIL freed_next_cycle got gnt=%b preg0=%0d want gnt=01 preg0=33", alloc_gnt, alloc_preg[5:0]);
    end
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd28) begin errors++; $display("FAIL freed_reuse_count got %0d want 28", free_count); end
  endtask

  task automatic test_slot_gap();
    set_alloc(2'b10, 5'd0, 5'd9);
    #1;
    checks++;
    if (alloc_gnt !== 2'b10 || alloc_preg !== {6'd36, 6'd0}) begin
      errors++; $display("FAIL slot_gap got gnt=%b preg=%h want gnt=10 preg1=36", alloc_gnt, alloc_preg);
    end
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd27) begin errors++; $display("FAIL slot_gap_count got %0d want 27", free_count); end
  endtask

  task automatic test_exhaust();
    for (int i = 0; i < 13; i++) begin
      set_alloc(2'b11, 5'd1, 5'd2);
      #1;
      checks++;
      if (alloc_gnt !== 2'b11 || alloc_preg[5:0] !== 6'(37 + 2*i) || alloc_preg[11:6] !== 6'(38 + 2*i)) begin
        errors++; $display("FAIL exhaust_step%0d got gnt=%b preg0=%0d preg1=%0d want 11 %0d %0d",
                            i, alloc_gnt, alloc_preg[5:0], alloc_preg[11:6], 37 + 2*i, 38 + 2*i);
      end
      tick();
    end
    checks++;
    if (free_count !== 7'd1) begin errors++; $display("FAIL exhaust_count got %0d want 1", free_count); end
    #1;
    checks++;
    if (alloc_gnt !== 2'b01 || alloc_preg !== {6'd0, 6'd63}) begin
      errors++; $display("FAIL last_one got gnt=%b preg=%h want gnt=01 preg0=63 preg1=0", alloc_gnt, alloc_preg);
    end
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty got count=%0d empty=%b want 0 1", free_count, empty);
    end
  endtask

  task automatic test_bypass_when_full();
    set_free(2'b01, 6'd40, 6'd0);
    set_alloc(2'b11, 5'd1, 5'd2);
    #1;
    checks++;
`ifdef FL_FREE_BYPASS_EN
    if (alloc_gnt !== 2'b01 || alloc_preg !== {6'd0, 6'd40}) begin
      errors++; $display("FAIL bypass_grant got gnt=%b preg=%h want gnt=01 preg0=40", alloc_gnt, alloc_preg);
    end
`else
    if (alloc_gnt !== 2'b00 || alloc_preg !== 12'd0) begin
      errors++; $display("FAIL full_no_grant got gnt=%b preg=%h want gnt=00 preg=0", alloc_gnt, alloc_preg);
    end
`endif
    tick();
    set_free(2'b00, 6'd0, 6'd0);
    set_alloc(2'b01, 5'd1, 5'd0);
    checks++;
`ifdef FL_FREE_BYPASS_EN
    if (free_count !== 7'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", free_count); end
`else
    if (free_count !== 7'd1) begin errors++; $display("FAIL free_full_count got %0d want 1", free_count); end
`endif
    #1;
    checks++;
`ifdef FL_FREE_BYPASS_EN
    if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL bypass_after got gnt=%b want 00", alloc_gnt); end
`else
    if (alloc_gnt !== 2'b01 || alloc_preg[5:0] !== 6'd40) begin
      errors++; $display("FAIL freed_40 got gnt=%b preg0=%0d want gnt=01 preg0=40", alloc_gnt, alloc_preg[5:0]);
    end
`endif
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd0) begin errors++; $display("FAIL refill_count got %0d want 0", free_count); end
  endtask

  task automatic test_multi_free();
    set_free(2'b11, 6'd45, 6'd46);
    tick();
    set_free(2'b00, 6'd0, 6'd0);
    checks++;
    if (free_count !== 7'd2 || empty !== 1'b0) begin
      errors++; $display("FAIL multi_free got count=%0d empty=%b want 2 0", free_count, empty);
    end
  endtask

  task automatic test_errors();
    set_free(2'b01, 6'd0, 6'd0);
    #1;
    checks++;
    if (dut.dbl_free_err !== 1'b0) begin errors++; $display("FAIL free0_flag got %b want 0", dut.dbl_free_err); end
    tick();
    checks++;
    if (free_count !== 7'd2) begin errors++; $display("FAIL free0_count got %0d want 2", free_count); end
    set_free(2'b01, 6'd50, 6'd0);
    tick();
    checks++;
    if (free_count !== 7'd3) begin errors++; $display("FAIL free50_count got %0d want 3", free_count); end
    set_free(2'b11, 6'd0, 6'd50);
    #1;
    checks++;
    if (dut.dbl_free_err !== 1'b1) begin errors++; $display("FAIL dbl_free_flag got %b want 1", dut.dbl_free_err); end
    tick();
    checks++;
    if (free_count !== 7'd3) begin errors++; $display("FAIL dbl_free_count got %0d want 3", free_count); end
    set_free(2'b11, 6'd51, 6'd51);
    #1;
    checks++;
    if (dut.dup_free_err !== 1'b1) begin errors++; $display("FAIL dup_flag got %b want 1", dut.dup_free_err); end
    tick();
    set_free(2'b00, 6'd0, 6'd0);
    checks++;
    if (free_count !== 7'd4) begin errors++; $display("FAIL dup_count got %0d want 4", free_count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < NA; i++) rrf_map[i*PW +: PW] = 6'(i + 1);
    flush = 1'b1;
    set_alloc(2'b11, 5'd1, 5'd2);
    set_free(2'b01, 6'd60, 6'd0);
    #1;
    checks++;
    if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL flush_gnt got %b want 00", alloc_gnt); end
    tick();
    flush = 1'b0;
    set_free(2'b00, 6'd0, 6'd0);
    set_alloc(2'b01, 5'd4, 5'd0);
    checks++;
    if (free_count !== 7'd31) begin errors++; $display("FAIL flush_count got %0d want 31", free_count); end
    #1;
    checks++;
    if (alloc_gnt !== 2'b01 || alloc_preg[5:0] !== 6'd33) begin
      errors++; $display("FAIL flush_first got gnt=%b preg0=%0d want gnt=01 preg0=33", alloc_gnt, alloc_preg[5:0]);
    end
    tick();
    set_alloc(2'b00, 5'd0, 5'd0);
    checks++;
    if (free_count !== 7'd30) begin errors++; $display("FAIL post_flush_count got %0d want 30", free_count); end
  endtask

  task automatic test_rst_priority();
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    checks++;
    if (free_count !== 7'd32) begin errors++; $display("FAIL rst_over_flush got %0d want 32", free_count); end
  endtask

  initial begin
    test_reset();
    test_basic_alloc();
    test_zero_rd();
    test_free_visibility();
    test_slot_gap();
    test_exhaust();
    test_bypass_when_full();
    test_multi_free();
    test_errors();
    test_flush();
    test_rst_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
